// File: rtl/rx_ltssm_pkg.sv
// Shared definitions for the receive-side LTSSM checker: substate encodings,
// ordered-set symbol constants and per-substate exit counts.
package rx_ltssm_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET   = 4'd0,
    DETECT_ACTIVE  = 4'd1,
    POLLING_ACTIVE = 4'd2,
    POLLING_CONFIG = 4'd3,
    CFG_LW_START   = 4'd4,
    CFG_LW_ACCEPT  = 4'd5,
    CFG_LN_WAIT    = 4'd6,
    CFG_LN_ACCEPT  = 4'd7,
    CFG_COMPLETE   = 4'd8,
    CFG_IDLE       = 4'd9,
    L0             = 4'd10,
    REC_RCVR_LOCK  = 4'd11,
    REC_RCVR_CFG   = 4'd12,
    REC_IDLE       = 4'd13
  } substate_e;

  localparam int NUM_LANES     = 16;
  localparam int SYMS_PER_LANE = 16;
  localparam int LANE_W        = 8 * SYMS_PER_LANE;
  localparam int OS_W          = NUM_LANES * LANE_W;

  localparam logic [7:0] TS1_SYM  = 8'h1E;
  localparam logic [7:0] TS2_SYM  = 8'h2D;
  localparam logic [7:0] PAD_SYM  = 8'hF7;
  localparam logic [7:0] IDLE_SYM = 8'h00;

  localparam logic [3:0] CNT_LONG  = 4'd8;
  localparam logic [3:0] CNT_SHORT = 4'd2;
  localparam logic [3:0] CNT_ONE   = 4'd1;

  // Zero means the substate has no count-based exit.
  function automatic logic [3:0] exit_threshold(input logic [3:0] s);
    case (s)
      POLLING_ACTIVE, POLLING_CONFIG, CFG_COMPLETE, CFG_IDLE,
      REC_RCVR_LOCK, REC_RCVR_CFG, REC_IDLE:              return CNT_LONG;
      CFG_LW_START, CFG_LW_ACCEPT, CFG_LN_WAIT, CFG_LN_ACCEPT: return CNT_SHORT;
      L0:                                                  return CNT_ONE;
      default:                                             return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] exit_target(input logic [3:0] s);
    case (s)
      DETECT_QUIET:   return DETECT_ACTIVE;
      DETECT_ACTIVE:  return POLLING_ACTIVE;
      POLLING_ACTIVE: return POLLING_CONFIG;
      POLLING_CONFIG: return CFG_LW_START;
      CFG_LW_START:   return CFG_LW_ACCEPT;
      CFG_LW_ACCEPT:  return CFG_LN_WAIT;
      CFG_LN_WAIT:    return CFG_LN_ACCEPT;
      CFG_LN_ACCEPT:  return CFG_COMPLETE;
      CFG_COMPLETE:   return CFG_IDLE;
      CFG_IDLE:       return L0;
      L0:             return REC_RCVR_LOCK;
      REC_RCVR_LOCK:  return REC_RCVR_CFG;
      REC_RCVR_CFG:   return REC_IDLE;
      REC_IDLE:       return L0;
      default:        return DETECT_QUIET;
    endcase
  endfunction

endpackage

// File: rtl/rx_ltssm_os_match.sv
// Combinational ordered-set classifier: per-lane type and field checks,
// AND-reduced over the detected lanes 0..N-1 (no lanes means no match).
module rx_ltssm_os_match
  import rx_ltssm_pkg::*;
(
  input  logic [OS_W-1:0] orderedSets,
  input  logic [4:0]      numberOfDetectedLanes,
  input  logic [7:0]      linkNumber,
  output logic            isTs1,
  output logic            isTs2,
  output logic            isTsAny,
  output logic            isIdle,
  output logic            linkOk,
  output logic            linkNotPad,
  output logic            laneOk
);

  logic       any_lane;
  logic [7:0] sym0;
  logic [7:0] sym1;
  logic [7:0] sym2;

  always_comb begin
    any_lane   = (numberOfDetectedLanes != 5'd0);
    isTs1      = any_lane;
    isTs2      = any_lane;
    isTsAny    = any_lane;
    isIdle     = any_lane;
    linkOk     = any_lane;
    linkNotPad = any_lane;
    laneOk     = any_lane;
    sym0       = 8'h00;
    sym1       = 8'h00;
    sym2       = 8'h00;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i < int'(numberOfDetectedLanes)) begin
        sym0 = orderedSets[LANE_W*i +: 8];
        sym1 = orderedSets[LANE_W*i+8 +: 8];
        sym2 = orderedSets[LANE_W*i+16 +: 8];
        isTs1      &= (sym0 == TS1_SYM);
        isTs2      &= (sym0 == TS2_SYM);
        isTsAny    &= (sym0 == TS1_SYM) || (sym0 == TS2_SYM);
        isIdle     &= (orderedSets[LANE_W*i +: LANE_W] == {SYMS_PER_LANE{IDLE_SYM}});
        linkOk     &= (sym1 == linkNumber);
        linkNotPad &= (sym1 != PAD_SYM);
        laneOk     &= (sym2 == 8'(i));
      end
    end
  end

endmodule

// File: rtl/rx_ltssm.sv
// Receive-side LTSSM checker: counts qualifying ordered sets per substate and
// pulses finish/exitTo on exit. Optional timer enabled by RX_LTSSM_TIMEOUT_EN.
module rx_ltssm
  import rx_ltssm_pkg::*;
#(
  parameter int DEVICE_TYPE    = 0,
  parameter int TIMEOUT_CYCLES = 3000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OS_W-1:0] orderedSets,
  input  logic [4:0]      numberOfDetectedLanes,
  input  logic [3:0]      substate,
  input  logic [7:0]      linkNumber,
  input  logic            forceDetect,
  input  logic            rxElectricalIdle,
  input  logic            validOrderedSets,
  output logic [7:0]      rateid,
  output logic            upConfigureCapability,
  output logic            finish,
  output logic [3:0]      exitTo,
  output logic            linkUp,
  output logic            witeUpconfigureCapability,
  output logic            writerateid,
  output logic            disableDescrambler
);

  logic is_ts1, is_ts2, is_ts_any, is_idle, link_ok, link_not_pad, lane_ok;

  rx_ltssm_os_match u_os_match (
    .orderedSets           (orderedSets),
    .numberOfDetectedLanes (numberOfDetectedLanes),
    .linkNumber            (linkNumber),
    .isTs1                 (is_ts1),
    .isTs2                 (is_ts2),
    .isTsAny               (is_ts_any),
    .isIdle                (is_idle),
    .linkOk                (link_ok),
    .linkNotPad            (link_not_pad),
    .laneOk                (lane_ok)
  );

  logic [3:0] count_q, count_d, count_inc, base_count, thr;
  logic [3:0] prev_substate_q;
  logic [3:0] exit_to_q, exit_to_d, cnt_target, tmo_target;
  logic [7:0] rateid_q, rateid_d;
  logic       done_q, done_d, done_eff, sub_changed;
  logic       os_match, lw_start_link, cnt_exit, tmo_exit, force_fire, fire, cap_ok;
  logic       finish_q, finish_d, link_up_q, link_up_d;
  logic       upcfg_q, upcfg_d, descr_q, descr_d;
  logic       wr_rateid_q, wr_rateid_d, wr_upcfg_q, wr_upcfg_d;

`ifdef RX_LTSSM_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] FULL_TIME = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] HALF_TIME = TIMER_W'(TIMEOUT_CYCLES / 2);

  logic [TIMER_W-1:0] timer_q, timer_d;

  // The substate-change cycle counts as the first cycle in the new substate.
  always_comb begin
    timer_d = timer_q;
    if (sub_changed) begin
      timer_d = TIMER_W'(1);
    end else if (timer_q != FULL_TIME) begin
      timer_d = timer_q + 1'b1;
    end
    tmo_exit   = 1'b0;
    tmo_target = DETECT_QUIET;
    case (substate)
      DETECT_QUIET: begin
        tmo_exit   = (timer_d == HALF_TIME);
        tmo_target = DETECT_ACTIVE;
      end
      POLLING_ACTIVE, POLLING_CONFIG, CFG_LW_START, CFG_LW_ACCEPT, CFG_LN_WAIT,
      CFG_LN_ACCEPT, CFG_COMPLETE, CFG_IDLE, REC_RCVR_LOCK, REC_RCVR_CFG, REC_IDLE:
        tmo_exit = (timer_d == FULL_TIME);
      default: tmo_exit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo_exit       = 1'b0;
  assign tmo_target     = DETECT_QUIET;
`endif

  assign lw_start_link = (DEVICE_TYPE == 0) ? link_ok : link_not_pad;

  always_comb begin
    sub_changed = (substate != prev_substate_q);
    done_eff    = done_q && !sub_changed;
    base_count  = sub_changed ? 4'd0 : count_q;

    case (substate)
      POLLING_ACTIVE, L0, REC_RCVR_LOCK:           os_match = is_ts_any;
      POLLING_CONFIG, CFG_LN_WAIT, REC_RCVR_CFG:   os_match = is_ts2;
      CFG_LW_START:                                os_match = is_ts1 && lw_start_link;
      CFG_LW_ACCEPT:                               os_match = is_ts1 && link_ok;
      CFG_LN_ACCEPT:                               os_match = is_ts2 && lane_ok;
      CFG_COMPLETE:                                os_match = is_ts2 && link_ok && lane_ok;
      CFG_IDLE, REC_IDLE:                          os_match = is_idle;
      default:                                     os_match = 1'b0;
    endcase

    count_inc = base_count;
    if (validOrderedSets) begin
      if (!os_match)                count_inc = 4'd0;
      else if (base_count != 4'hF)  count_inc = base_count + 4'd1;
    end

    thr        = exit_threshold(substate);
    cnt_target = exit_target(substate);
    if (substate == DETECT_QUIET)       cnt_exit = !rxElectricalIdle;
    else if (substate == DETECT_ACTIVE) cnt_exit = (numberOfDetectedLanes != 5'd0);
    else                                cnt_exit = (thr != 4'd0) && (count_inc >= thr);

    // A held forceDetect fires once, not every cycle.
    force_fire = forceDetect && !(done_eff && exit_to_q == DETECT_QUIET);
    fire       = force_fire || (!done_eff && (cnt_exit || tmo_exit));
    cap_ok     = fire && !force_fire && cnt_exit;

    exit_to_d = exit_to_q;
    if (force_fire)    exit_to_d = DETECT_QUIET;
    else if (cnt_exit) exit_to_d = cnt_target;
    else if (tmo_exit) exit_to_d = tmo_target;

    count_d  = force_fire ? 4'd0 : count_inc;
    done_d   = done_eff || fire;
    finish_d = fire;

    link_up_d = link_up_q;
    if (fire && exit_to_d == L0)                link_up_d = 1'b1;
    else if (fire && exit_to_d == DETECT_QUIET) link_up_d = 1'b0;

    rateid_d    = rateid_q;
    upcfg_d     = upcfg_q;
    descr_d     = descr_q;
    wr_rateid_d = 1'b0;
    wr_upcfg_d  = 1'b0;
    if (cap_ok && (substate == POLLING_CONFIG || substate == CFG_COMPLETE)) begin
      rateid_d    = orderedSets[39:32];
      wr_rateid_d = 1'b1;
    end
    if (cap_ok && substate == CFG_COMPLETE) begin
      upcfg_d    = orderedSets[38];
      descr_d    = orderedSets[43];
      wr_upcfg_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q         <= '0;
      prev_substate_q <= '0;
      exit_to_q       <= '0;
      done_q          <= 1'b0;
      finish_q        <= 1'b0;
      link_up_q       <= 1'b0;
      rateid_q        <= '0;
      upcfg_q         <= 1'b0;
      descr_q         <= 1'b0;
      wr_rateid_q     <= 1'b0;
      wr_upcfg_q      <= 1'b0;
    end else begin
      count_q         <= count_d;
      prev_substate_q <= substate;
      exit_to_q       <= exit_to_d;
      done_q          <= done_d;
      finish_q        <= finish_d;
      link_up_q       <= link_up_d;
      rateid_q        <= rateid_d;
      upcfg_q         <= upcfg_d;
      descr_q         <= descr_d;
      wr_rateid_q     <= wr_rateid_d;
      wr_upcfg_q      <= wr_upcfg_d;
    end
  end

  assign finish                    = finish_q;
  assign exitTo                    = exit_to_q;
  assign linkUp                    = link_up_q;
  assign rateid                    = rateid_q;
  assign upConfigureCapability     = upcfg_q;
  assign disableDescrambler        = descr_q;
  assign writerateid               = wr_rateid_q;
  assign witeUpconfigureCapability = wr_upcfg_q;

endmodule

// File: tb/tb_rx_ltssm.sv
// Directed self-checking bench for rx_ltssm; the timeout scenario runs only
// when RX_LTSSM_TIMEOUT_EN is defined.
module tb_rx_ltssm;
  import rx_ltssm_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [2047:0] orderedSets;
  logic [4:0]    numberOfDetectedLanes;
  logic [3:0]    substate;
  logic [7:0]    linkNumber;
  logic          forceDetect;
  logic          rxElectricalIdle;
  logic          validOrderedSets;
  logic [7:0]    rateid;
  logic          upConfigureCapability;
  logic          finish;
  logic [3:0]    exitTo;
  logic          linkUp;
  logic          witeUpconfigureCapability;
  logic          writerateid;
  logic          disableDescrambler;

  int checks = 0;
  int errors = 0;
  logic finishSeen;
  logic [2047:0] ts1Os, ts2Os, badOs, mixOs, goodOs, badLaneOs;

`ifdef RX_LTSSM_TIMEOUT_EN
  localparam int QUIET_CYCLES = 40;
`else
  localparam int QUIET_CYCLES = 100;
`endif

  always #5 clk = ~clk;

  rx_ltssm #(.DEVICE_TYPE(0), .TIMEOUT_CYCLES(100)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .orderedSets               (orderedSets),
    .numberOfDetectedLanes     (numberOfDetectedLanes),
    .substate                  (substate),
    .linkNumber                (linkNumber),
    .forceDetect               (forceDetect),
    .rxElectricalIdle          (rxElectricalIdle),
    .validOrderedSets          (validOrderedSets),
    .rateid                    (rateid),
    .upConfigureCapability     (upConfigureCapability),
    .finish                    (finish),
    .exitTo                    (exitTo),
    .linkUp                    (linkUp),
    .witeUpconfigureCapability (witeUpconfigureCapability),
    .writerateid               (writerateid),
    .disableDescrambler        (disableDescrambler)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one cycle of ordered sets; returns #1 after the consuming edge.
  task automatic applyStimulus(input logic valid, input logic [2047:0] os);
    orderedSets      = os;
    validOrderedSets = valid;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2047:0] buildOs(input logic [7:0] sym0, input logic [7:0] link,
                                            input logic [7:0] sym4, input logic [7:0] sym5);
    logic [2047:0] os = '0;
    for (int i = 0; i < 16; i++) begin
      os[128*i +: 8]    = sym0;
      os[128*i+8 +: 8]  = link;
      os[128*i+16 +: 8] = 8'(i);
      os[128*i+24 +: 8] = 8'h10;
      os[128*i+32 +: 8] = sym4;
      os[128*i+40 +: 8] = sym5;
      for (int k = 6; k < 16; k++) os[128*i+8*k +: 8] = 8'h4A;
    end
    return os;
  endfunction

  initial begin
    reset = 1'b1; orderedSets = '0; validOrderedSets = 1'b0; numberOfDetectedLanes = 5'd0;
    substate = 4'd0; linkNumber = 8'd0; forceDetect = 1'b0; rxElectricalIdle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_finish", 32'(finish), 0);
    checkOutput("rst_exitTo", 32'(exitTo), 0);
    checkOutput("rst_linkUp", 32'(linkUp), 0);
    checkOutput("rst_rateid", 32'(rateid), 0);
    checkOutput("rst_upcfg", 32'(upConfigureCapability), 0);
    checkOutput("rst_descr", 32'(disableDescrambler), 0);
    checkOutput("rst_wrRate", 32'(writerateid), 0);
    checkOutput("rst_wrUpcfg", 32'(witeUpconfigureCapability), 0);
    reset = 1'b0;

    // Detect.Quiet held by electrical idle, then released.
    finishSeen = 1'b0;
    repeat (QUIET_CYCLES) begin
      applyStimulus(1'b0, '0);
      finishSeen |= finish;
    end
    checkOutput("quiet_noFinish", 32'(finishSeen), 0);
    rxElectricalIdle = 1'b0;
    applyStimulus(1'b0, '0);
    checkOutput("quiet_finish", 32'(finish), 1);
    checkOutput("quiet_exitTo", 32'(exitTo), 1);
    applyStimulus(1'b0, '0);
    checkOutput("quiet_silent", 32'(finish), 0);

    // Detect.Active waits for detected lanes.
    substate = 4'd1;
    applyStimulus(1'b0, '0);
    checkOutput("active_noLanes", 32'(finish), 0);
    numberOfDetectedLanes = 5'd4;
    applyStimulus(1'b0, '0);
    checkOutput("active_finish", 32'(finish), 1);
    checkOutput("active_exitTo", 32'(exitTo), 2);

    // Polling.Active: corrupt symbol 0 clears, invalid cycle holds, lane-3 TS2 counts.
    substate = 4'd2;
    ts1Os = buildOs(TS1_SYM, PAD_SYM, 8'h00, 8'h00);
    ts1Os[128*5 +: 8] = 8'h99;
    badOs = ts1Os;
    badOs[128*1 +: 8] = 8'h55;
    mixOs = ts1Os;
    mixOs[128*3 +: 8] = TS2_SYM;
    finishSeen = 1'b0;
    repeat (3) begin applyStimulus(1'b1, ts1Os); finishSeen |= finish; end
    applyStimulus(1'b1, badOs); finishSeen |= finish;
    repeat (4) begin applyStimulus(1'b1, ts1Os); finishSeen |= finish; end
    applyStimulus(1'b0, badOs); finishSeen |= finish;
    applyStimulus(1'b1, mixOs); finishSeen |= finish;
    repeat (2) begin applyStimulus(1'b1, ts1Os); finishSeen |= finish; end
    checkOutput("poll_before8", 32'(finishSeen), 0);
    applyStimulus(1'b1, ts1Os);
    checkOutput("poll_finish", 32'(finish), 1);
    checkOutput("poll_exitTo", 32'(exitTo), 3);
    applyStimulus(1'b1, ts1Os);
    checkOutput("poll_silent", 32'(finish), 0);

    // Config.LinkWidth.Start on a downstream port needs the expected link number.
    substate = 4'd4;
    linkNumber = 8'h05;
    finishSeen = 1'b0;
    repeat (2) begin applyStimulus(1'b1, buildOs(TS1_SYM, 8'h06, 8'h00, 8'h00)); finishSeen |= finish; end
    applyStimulus(1'b1, buildOs(TS1_SYM, 8'h05, 8'h00, 8'h00)); finishSeen |= finish;
    checkOutput("lwStart_wrongLink", 32'(finishSeen), 0);
    applyStimulus(1'b1, buildOs(TS1_SYM, 8'h05, 8'h00, 8'h00));
    checkOutput("lwStart_finish", 32'(finish), 1);
    checkOutput("lwStart_exitTo", 32'(exitTo), 5);

    // Config.Complete with captures.
    substate = 4'd8;
    goodOs = buildOs(TS2_SYM, 8'h05, 8'h46, 8'h08);
    badLaneOs = goodOs;
    badLaneOs[128*2+16 +: 8] = 8'h07;
    finishSeen = 1'b0;
    repeat (4) begin applyStimulus(1'b1, goodOs); finishSeen |= finish; end
    applyStimulus(1'b1, badLaneOs); finishSeen |= finish;
    repeat (7) begin applyStimulus(1'b1, goodOs); finishSeen |= finish; end
    checkOutput("cfgComp_before8", 32'(finishSeen), 0);
    checkOutput("cfgComp_noStrobe", 32'(writerateid), 0);
    applyStimulus(1'b1, goodOs);
    checkOutput("cfgComp_finish", 32'(finish), 1);
    checkOutput("cfgComp_exitTo", 32'(exitTo), 9);
    checkOutput("cfgComp_rateid", 32'(rateid), 32'h46);
    checkOutput("cfgComp_upcfg", 32'(upConfigureCapability), 1);
    checkOutput("cfgComp_descr", 32'(disableDescrambler), 1);
    checkOutput("cfgComp_wrRate", 32'(writerateid), 1);
    checkOutput("cfgComp_wrUpcfg", 32'(witeUpconfigureCapability), 1);
    applyStimulus(1'b0, '0);
    checkOutput("cfgComp_wrRateOff", 32'(writerateid), 0);
    checkOutput("cfgComp_wrUpcfgOff", 32'(witeUpconfigureCapability), 0);
    checkOutput("cfgComp_rateHeld", 32'(rateid), 32'h46);

    // Config.Idle to L0 raises linkUp; forceDetect then drops it.
    substate = 4'd9;
    finishSeen = 1'b0;
    repeat (7) begin applyStimulus(1'b1, '0); finishSeen |= finish; end
    checkOutput("cfgIdle_before8", 32'(finishSeen), 0);
    checkOutput("cfgIdle_linkDown", 32'(linkUp), 0);
    applyStimulus(1'b1, '0);
    checkOutput("cfgIdle_finish", 32'(finish), 1);
    checkOutput("cfgIdle_exitTo", 32'(exitTo), 10);
    checkOutput("cfgIdle_linkUp", 32'(linkUp), 1);
    forceDetect = 1'b1;
    applyStimulus(1'b0, '0);
    checkOutput("force_finish", 32'(finish), 1);
    checkOutput("force_exitTo", 32'(exitTo), 0);
    checkOutput("force_linkUp", 32'(linkUp), 0);
    applyStimulus(1'b0, '0);
    checkOutput("force_once", 32'(finish), 0);
    forceDetect = 1'b0;

    // L0 leaves on a single TS.
    substate = 4'd10;
    applyStimulus(1'b1, buildOs(TS2_SYM, 8'h05, 8'h00, 8'h00));
    checkOutput("l0_finish", 32'(finish), 1);
    checkOutput("l0_exitTo", 32'(exitTo), 11);

    // Undefined substate never finishes.
    substate = 4'd14;
    finishSeen = 1'b0;
    repeat (10) begin applyStimulus(1'b1, ts1Os); finishSeen |= finish; end
    checkOutput("undef_noFinish", 32'(finishSeen), 0);

`ifdef RX_LTSSM_TIMEOUT_EN
    substate = 4'd3;
    finishSeen = 1'b0;
    repeat (99) begin applyStimulus(1'b0, '0); finishSeen |= finish; end
    checkOutput("tmo_before", 32'(finishSeen), 0);
    applyStimulus(1'b0, '0);
    checkOutput("tmo_finish", 32'(finish), 1);
    checkOutput("tmo_exitTo", 32'(exitTo), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
